// File: rtl/lane_encoder.sv
// Per-lane 64b/66b transmit encoder: prepends the sync header and scrambles
// the payload with the self-synchronous polynomial G(x) = 1 + x^39 + x^58.
// Output is registered and comes out one clock after the input, with no stalls.

`ifndef ENCODER_DATA_IN_SIZE
`define ENCODER_DATA_IN_SIZE 64
`endif

module lane_encoder #(
  parameter int unsigned DATA_W   = `ENCODER_DATA_IN_SIZE,  // only 64 is supported
  parameter logic [57:0] SCR_SEED = 58'h0,
  parameter bit          SCR_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              scr_bypass,
  output logic              out_valid,
  output logic [DATA_W+1:0] block_out,
  output logic [15:0]       blk_cnt
);

  logic [DATA_W-1:0] scr_payload;
  logic [DATA_W-1:0] payload_d;
  logic [1:0]        sync_hdr;

  if (SCR_EN) begin : g_scr
    logic [57:0] scr_state_q;

    // Unroll 64 serial scrambler steps. ext[0..57] is the held state, where
    // ext[57] is the most recent bit; ext[58+k] is scrambled bit x_k.
    always_comb begin
      logic [DATA_W+57:0] ext;
      ext = '0;
      ext[57:0] = scr_state_q;
      for (int k = 0; k < int'(DATA_W); k++) begin
        ext[58+k] = data_in[k] ^ ext[k+19] ^ ext[k];
      end
      scr_payload = ext[DATA_W+57:58];
    end

    // State advances only on accepted, non-bypassed blocks; the newest 58
    // scrambled bits become the state for the next block.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        scr_state_q <= SCR_SEED;
      end else if (in_valid && !scr_bypass) begin
        scr_state_q <= scr_payload[DATA_W-1:DATA_W-58];
      end
    end
  end else begin : g_no_scr
    assign scr_payload = data_in;
  end

  // Select the payload and the unscrambled sync header.
  always_comb begin
    payload_d = scr_bypass ? data_in : scr_payload;
    sync_hdr  = ctrl_in ? 2'b10 : 2'b01;
  end

  // Output register: updates only when a block is accepted, so idle-cycle
  // input values never reach block_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      block_out <= '0;
      blk_cnt   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        block_out <= {sync_hdr, payload_d};
        blk_cnt   <= blk_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lane_encoder.sv
// Directed bench for lane_encoder: reset, scrambler vectors, control header,
// gap continuity, bypass and mid-stream reset.

module tb_lane_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        ctrl_in;
  logic [63:0] data_in;
  logic        scr_bypass;
  logic        out_valid;
  logic [65:0] block_out;
  logic [15:0] blk_cnt;

  int total;
  int bad;

  localparam logic [65:0] Blk1 = {2'b01, 64'h0400_0080_0000_0001};
  localparam logic [65:0] Blk2 = {2'b01, 64'h0030_0000_0000_4000};

  lane_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .ctrl_in    (ctrl_in),
    .data_in    (data_in),
    .scr_bypass (scr_bypass),
    .out_valid  (out_valid),
    .block_out  (block_out),
    .blk_cnt    (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one block for one edge, then sample 1 time unit after the edge.
  task automatic send(input logic ctrl, input logic [63:0] data, input logic byp);
    in_valid   = 1'b1;
    ctrl_in    = ctrl;
    data_in    = data;
    scr_bypass = byp;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    data_in    = 'x;
    scr_bypass = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", {65'd0, out_valid}, 66'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    ctrl_in    = 1'b0;
    data_in    = 64'h1;
    scr_bypass = 1'b0;

    // Reset held with in_valid asserted.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {65'd0, out_valid}, 66'd0);
    check("rst_block", block_out, 66'd0);
    check("rst_cnt", {50'd0, blk_cnt}, 66'd0);

    // Release with block 1 still presented; it appears after the next edge.
    rst_n = 1'b1;
    send(1'b0, 64'h1, 1'b0);
    check("v1_valid", {65'd0, out_valid}, 66'd1);
    check("v1_block", block_out, Blk1);
    check("v1_cnt", {50'd0, blk_cnt}, 66'd1);
    send(1'b0, 64'h0, 1'b0);
    check("v2_block", block_out, Blk2);
    check("v2_cnt", {50'd0, blk_cnt}, 66'd2);

    // Control header, zero seed, zero data, three times.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 64'h0, 1'b0);
      check("ctrl_block", block_out, {2'b10, 64'h0});
    end
    check("ctrl_cnt", {50'd0, blk_cnt}, 66'd3);

    // Gap continuity with five idle cycles and X on data_in.
    do_reset();
    send(1'b0, 64'h1, 1'b0);
    check("gap_b1", block_out, Blk1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("gap_valid", {65'd0, out_valid}, 66'd0);
      check("gap_hold", block_out, Blk1);
    end
    check("gap_cnt_hold", {50'd0, blk_cnt}, 66'd1);
    send(1'b0, 64'h0, 1'b0);
    check("gap_b2", block_out, Blk2);
    check("gap_cnt", {50'd0, blk_cnt}, 66'd2);

    // Bypass on block 1 leaves the state at the zero seed.
    do_reset();
    send(1'b0, 64'h1, 1'b1);
    check("byp_b1", block_out, {2'b01, 64'h1});
    send(1'b0, 64'h0, 1'b0);
    check("byp_b2", block_out, {2'b01, 64'h0});
    check("byp_cnt", {50'd0, blk_cnt}, 66'd2);

    // Mid-stream reset between blocks 1 and 2.
    do_reset();
    send(1'b0, 64'h1, 1'b0);
    check("mid_b1", block_out, Blk1);
    do_reset();
    check("mid_rst_block", block_out, 66'd0);
    send(1'b0, 64'h1, 1'b0);
    check("mid_b2", block_out, Blk1);
    check("mid_cnt", {50'd0, blk_cnt}, 66'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
